// File: rtl/ysyx_25030081_mdu_pkg.sv
// Shared definitions for the M-extension multiply/divide unit:
// funct3 opcodes, handshake FSM states and opcode helpers.
package ysyx_25030081_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/ysyx_25030081_mdu_iter.sv
// Unsigned W-bit iterative datapath: radix-2 shift-add multiply or restoring
// divide, one bit per step over a shared 2W-bit accumulator.
module ysyx_25030081_mdu_iter #(
    parameter int unsigned W  = 32,
    parameter int unsigned CW = $clog2(W) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear_i,
    input  logic           start_i,
    input  logic           step_i,
    input  logic           div_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           last_o,
    output logic [2*W-1:0] res_o
);

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   b_q, b_d;
    logic           div_q, div_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [W:0]     add_sum;
    logic [W:0]     mul_hi;
    logic [W:0]     rem_sh;
    logic [W-1:0]   diff;
    logic           ge;
    logic [2*W-1:0] stepped;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}.
    always_comb begin
        add_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, b_q};
        mul_hi  = acc_q[0] ? add_sum : {1'b0, acc_q[2*W-1:W]};
        rem_sh  = acc_q[2*W-1:W-1];
        ge      = (rem_sh >= {1'b0, b_q});
        diff    = rem_sh[W-1:0] - b_q;
        if (div_q) begin
            stepped = {(ge ? diff : rem_sh[W-1:0]), acc_q[W-2:0], ge};
        end else begin
            stepped = {mul_hi, acc_q[W-1:1]};
        end
    end

    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        div_d = div_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            acc_d = '0;
            b_d   = '0;
            div_d = 1'b0;
            cnt_d = '0;
        end else if (start_i) begin
            acc_d = {{W{1'b0}}, a_i};
            b_d   = b_i;
            div_d = div_i;
            cnt_d = '0;
        end else if (step_i) begin
            acc_d = stepped;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign last_o = step_i && (cnt_q == CW'(W - 1));
    assign res_o  = stepped;

endmodule

// File: rtl/ysyx_25030081_mdu.sv
// RV32M/RV64M multi-cycle multiply/divide unit: valid/ready handshake FSM,
// operand sign handling, early-out corner cases and result sign fix-up.
module ysyx_25030081_mdu
    import ysyx_25030081_mdu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            mdu_op,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] mdu_out
);

    localparam int unsigned W = DATA_WIDTH;

    mdu_state_e   state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic         neg_q, neg_d;
    logic [W-1:0] out_q, out_d;

    logic           s1, s2, n1, n2, neg_in;
    logic [W-1:0]   a_abs, b_abs;
    logic           div_zero, ovf, special;
    logic [W-1:0]   spec_res;
    logic           start, step, last;
    logic [2*W-1:0] res;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   div_raw, fix_res;

    always_comb begin
        s1 = (mdu_op == MDU_MULH) || (mdu_op == MDU_MULHSU) ||
             (mdu_op == MDU_DIV)  || (mdu_op == MDU_REM);
        s2 = (mdu_op == MDU_MULH) || (mdu_op == MDU_DIV) || (mdu_op == MDU_REM);
        n1 = s1 && op1[W-1];
        n2 = s2 && op2[W-1];
        a_abs = n1 ? (~op1 + 1'b1) : op1;
        b_abs = n2 ? (~op2 + 1'b1) : op2;
        // Remainder takes the dividend's sign; everything else the XOR.
        neg_in = (is_div(mdu_op) && mdu_op[1]) ? n1 : (n1 ^ n2);

        div_zero = is_div(mdu_op) && (op2 == '0);
        ovf      = ((mdu_op == MDU_DIV) || (mdu_op == MDU_REM)) &&
                   (op1 == {1'b1, {(W-1){1'b0}}}) && (op2 == '1);
        special  = div_zero || ovf;
        if (div_zero) begin
            spec_res = mdu_op[1] ? op1 : '1;
        end else begin
            spec_res = mdu_op[1] ? '0 : op1;
        end
    end

    always_comb begin
        prod_fix = neg_q ? (~res + 1'b1) : res;
        div_raw  = op_q[1] ? res[2*W-1:W] : res[W-1:0];
        if (is_div(op_q)) begin
            fix_res = neg_q ? (~div_raw + 1'b1) : div_raw;
        end else if (op_q == MDU_MUL) begin
            fix_res = prod_fix[W-1:0];
        end else begin
            fix_res = prod_fix[2*W-1:W];
        end
    end

    assign start = (state_q == ST_IDLE) && in_valid && !flush && !special;
    assign step  = (state_q == ST_BUSY) && !flush;

    ysyx_25030081_mdu_iter #(
        .W  (W),
        .CW (CNT_WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .start_i (start),
        .step_i  (step),
        .div_i   (is_div(mdu_op)),
        .a_i     (a_abs),
        .b_i     (b_abs),
        .last_o  (last),
        .res_o   (res)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        out_d   = out_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d  = mdu_op;
                        neg_d = neg_in;
                        if (special) begin
                            out_d   = spec_res;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (last) begin
                        out_d   = fix_res;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign mdu_out   = out_q;

endmodule
